// File: rtl/count_event_capture.sv
// Timestamps a selected edge of an asynchronous event line with the live counter
// value and queues the timestamps in a small FIFO with a valid/ready read side.
module count_event_capture #(
  parameter int CW          = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CW-1:0]            count_in,
  input  logic                     event_in,
  input  logic [1:0]               edge_sel,
  output logic [CW-1:0]            cap_data,
  output logic                     cap_valid,
  input  logic                     cap_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  input  logic                     ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int MW = $clog2(SYNC_STAGES + 1);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(0);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
  localparam logic [MW-1:0] MASK_ONE  = MW'(1);
  localparam logic [MW-1:0] MASK_ZERO = MW'(0);
  localparam logic [MW-1:0] MASK_LAST = MW'(SYNC_STAGES);
  localparam logic [CW-1:0] DATA_ZERO = CW'(0);

  typedef enum logic {MASK = 1'b0, RUN = 1'b1} mask_state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ev_d_q, ev_d_d;
  mask_state_t            state_q, state_d;
  logic [MW-1:0]          mask_cnt_q, mask_cnt_d;
  logic [CW-1:0]          mem_q [DEPTH];
  logic [CW-1:0]          mem_d [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic ev_s, rise_s, fall_s, edge_hit_s, cap_pulse_s;
  logic full_s, push_s, pop_s, drop_s;

  assign ev_s       = sync_q[SYNC_STAGES-1];
  assign cap_valid  = (cnt_q != CNT_ZERO);
  assign cap_data   = mem_q[rd_ptr_q];
  assign fill_level = cnt_q;
  assign overflow   = ovf_q;

  // Synchroniser shift, edge history and edge selection; edge_sel acts in the same cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], event_in};
    ev_d_d = ev_s;
    rise_s = ev_s & ~ev_d_q;
    fall_s = ~ev_s & ev_d_q;
    case (edge_sel)
      2'b00:   edge_hit_s = rise_s;
      2'b01:   edge_hit_s = fall_s;
      2'b10:   edge_hit_s = rise_s | fall_s;
      default: edge_hit_s = 1'b0;
    endcase
    if (state_q == RUN) begin
      cap_pulse_s = edge_hit_s;
    end else begin
      cap_pulse_s = 1'b0;
    end
  end

  // Post-reset mask: hides the spurious edge the chain sees while filling from reset.
  always_comb begin
    state_d    = state_q;
    mask_cnt_d = mask_cnt_q;
    case (state_q)
      MASK: begin
        if (mask_cnt_q == MASK_LAST) begin
          state_d = RUN;
        end else begin
          mask_cnt_d = mask_cnt_q + MASK_ONE;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = MASK;
    endcase
  end

  // FIFO bookkeeping: a pop frees the slot before the same-cycle push claims it.
  always_comb begin
    full_s   = (cnt_q == CNT_FULL);
    pop_s    = cap_valid & cap_ready;
    push_s   = cap_pulse_s & (~full_s | pop_s);
    drop_s   = cap_pulse_s & full_s & ~pop_s;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = count_in;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers; reset discards all stored timestamps at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= {SYNC_STAGES{1'b0}};
      ev_d_q     <= 1'b0;
      state_q    <= MASK;
      mask_cnt_q <= MASK_ZERO;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      cnt_q      <= CNT_ZERO;
      ovf_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_ZERO;
      end
    end else begin
      sync_q     <= sync_d;
      ev_d_q     <= ev_d_d;
      state_q    <= state_d;
      mask_cnt_q <= mask_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
    end
  end
endmodule

// File: tb/tb_count_event_capture.sv
// Scoreboard bench for count_event_capture: directed scenarios followed by random
// traffic, all checked against a sample-history reference model.
module tb_count_event_capture;
  localparam int CW    = 8;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] count_in;
  logic          event_in;
  logic [1:0]    edge_sel;
  logic [CW-1:0] cap_data;
  logic          cap_valid;
  logic          cap_ready;
  logic [2:0]    fill_level;
  logic          overflow;
  logic          ovf_clr;

  int n_pass  = 0;
  int n_total = 0;

  int mdl_q[$];
  int exp_q[$];
  bit evq[$];
  bit m_ovf = 1'b0;
  int m_t;
  bit m_cur, m_prev, m_push;

  always #5 clk = ~clk;

  count_event_capture #(.CW(CW), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .event_in(event_in),
    .edge_sel(edge_sel), .cap_data(cap_data), .cap_valid(cap_valid),
    .cap_ready(cap_ready), .fill_level(fill_level), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    count_in = count_in + 8'd1;
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_fill", int'(fill_level), 0);
    check("rst_valid", int'(cap_valid), 0);
    check("rst_ovf", int'(overflow), 0);
    repeat (cycles) @(posedge clk);
    #1;
    reset    = 1'b0;
    count_in = 8'd0;
  endtask

  // Reference model: a capture at edge t (counted from reset release) exists when the
  // event samples taken SS and SS+1 edges earlier show the selected transition.
  always @(negedge clk) begin
    if (reset) begin
      mdl_q.delete();
      exp_q.delete();
      evq.delete();
      m_ovf = 1'b0;
    end
    check("fill_level", int'(fill_level), mdl_q.size());
    check("cap_valid", int'(cap_valid), (mdl_q.size() > 0) ? 1 : 0);
    check("overflow", int'(overflow), int'(m_ovf));
    if (!reset) begin
      evq.push_back(event_in);
      m_t    = evq.size();
      m_push = 1'b0;
      if (m_t > SS + 1) begin
        m_cur  = evq[m_t-SS-1];
        m_prev = evq[m_t-SS-2];
        case (edge_sel)
          2'b00:   m_push = m_cur & !m_prev;
          2'b01:   m_push = !m_cur & m_prev;
          2'b10:   m_push = (m_cur != m_prev);
          default: m_push = 1'b0;
        endcase
      end
      if (mdl_q.size() > 0 && cap_ready) void'(mdl_q.pop_front());
      if (m_push && mdl_q.size() < DEPTH) begin
        mdl_q.push_back(int'(count_in));
        exp_q.push_back(int'(count_in));
      end else if (m_push) begin
        m_ovf = 1'b1;
      end else if (ovf_clr) begin
        m_ovf = 1'b0;
      end
    end
  end

  // Monitor: every accepted read must match the oldest expected timestamp.
  always @(negedge clk) begin : monitor
    int exp_v;
    if (!reset && cap_valid && cap_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", int'(cap_data), -1);
      end else begin
        exp_v = exp_q.pop_front();
        check("sb_data", int'(cap_data), exp_v);
      end
    end
  end

  initial begin : stim
    int prev;
    int drained;
    reset     = 1'b1;
    event_in  = 1'b1;
    edge_sel  = 2'b00;
    cap_ready = 1'b0;
    ovf_clr   = 1'b0;
    count_in  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    count_in = 8'd0;

    // Event held high through reset must not look like a rising edge.
    repeat (10) step();
    check("t1_fill", int'(fill_level), 0);
    check("t1_valid", int'(cap_valid), 0);
    event_in = 1'b0;

    // Rising edge seen at count 20 is stamped 22; falling edge ignored.
    for (int i = 0; i < 40 && count_in != 8'd20; i++) step();
    event_in = 1'b1;
    step();
    step();
    check("t2_not_yet", int'(cap_valid), 0);
    step();
    check("t2_valid", int'(cap_valid), 1);
    check("t2_data", int'(cap_data), 22);
    event_in = 1'b0;
    repeat (6) step();
    check("t2_fall_ignored", int'(fill_level), 1);
    cap_ready = 1'b1;
    step();
    cap_ready = 1'b0;
    check("t2_drained", int'(fill_level), 0);

    // Both edges, no reader: four stored, fifth dropped.
    edge_sel = 2'b10;
    for (int i = 0; i < 5; i++) begin
      event_in = ~event_in;
      repeat (5) step();
    end
    check("t3_full", int'(fill_level), 4);
    check("t3_ovf", int'(overflow), 1);

    // Clear in the same cycle as a drop: set wins; then clear alone.
    event_in = ~event_in;
    step();
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t5_set_wins", int'(overflow), 1);
    repeat (2) step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t5_cleared", int'(overflow), 0);

    // Push and pop in the same cycle while full.
    event_in = ~event_in;
    step();
    step();
    cap_ready = 1'b1;
    step();
    cap_ready = 1'b0;
    check("t4_fill", int'(fill_level), 4);
    check("t4_no_ovf", int'(overflow), 0);
    repeat (3) step();
    cap_ready = 1'b1;
    prev      = -1;
    drained   = 0;
    for (int i = 0; i < 8 && cap_valid; i++) begin
      check("t4_increasing", (int'(cap_data) > prev) ? 1 : 0, 1);
      prev = int'(cap_data);
      drained++;
      step();
    end
    cap_ready = 1'b0;
    check("t4_drain_count", drained, 4);

    // Reset mid-stream: contents discarded, early edge masked, later edge captured.
    edge_sel = 2'b00;
    event_in = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 2; i++) begin
      event_in = 1'b1;
      repeat (5) step();
      event_in = 1'b0;
      repeat (5) step();
    end
    check("t6_two", int'(fill_level), 2);
    pulse_reset(2);
    event_in = 1'b1;
    repeat (6) step();
    check("t6_masked", int'(fill_level), 0);
    event_in = 1'b0;
    repeat (4) step();
    event_in = 1'b1;
    repeat (3) step();
    check("t6_captured", int'(fill_level), 1);
    edge_sel = 2'b11;
    for (int i = 0; i < 4; i++) begin
      event_in = ~event_in;
      repeat (4) step();
    end
    check("t6_disabled", int'(fill_level), 1);
    pulse_reset(2);
    for (int i = 0; i < 4; i++) begin
      event_in = ~event_in;
      repeat (4) step();
    end
    check("t6_disabled_after_rst", int'(fill_level), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 31) == 0) edge_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) event_in = ~event_in;
      cap_ready = ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) count_in = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
      end
    end
    cap_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/count_event_capture.md
Name: count_event_capture

Overview:
- Downstream consumer of the 8-bit free-running event counter.
- Timestamps an external asynchronous event line by sampling the counter value on a selected edge of that line.
- Buffers the timestamps in a small FIFO and presents them to a reader over a valid/ready interface.
- Flags overflow when a capture arrives and no buffer space is free.

Parameters:
- CW, 8, width of count_in and cap_data.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, flip-flops in the event_in synchroniser; minimum 2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clock is clk.
- count_in  input  CW  live counter value from the upstream counter.
- event_in  input  1  asynchronous event line.
- edge_sel  input  2  00 rising, 01 falling, 10 both edges, 11 capture disabled.
- cap_data  output  CW  timestamp at the FIFO head.
- cap_valid  output  1  high when the FIFO is not empty.
- cap_ready  input  1  reader accepts cap_data when cap_valid && cap_ready.
- fill_level  output  $clog2(DEPTH)+1  number of stored entries, range 0..DEPTH.
- overflow  output  1  sticky; set when a capture is dropped.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset: all of the following clear to 0.
  - Sync chain, edge-detect history register, FIFO pointers.
  - fill_level, cap_valid, overflow, cap_data.
- Synchroniser:
  - event_in passes through SYNC_STAGES flops to give ev_s.
  - An additional history flop holds ev_d, the previous ev_s.
- Edge detection (combinational on ev_s/ev_d):
  - rise = ev_s & ~ev_d; fall = ~ev_s & ev_d.
  - The selected edge produces a 1-cycle cap_pulse.
  - edge_sel 11 forces cap_pulse = 0.
  - edge_sel is sampled each cycle; a change affects detection in the same cycle. No internal edge_sel register.
- Post-reset mask:
  - cap_pulse is suppressed for the first SYNC_STAGES+1 clk cycles after reset deasserts.
  - Implement with a small counter or state: states MASK then RUN.
  - Effect: event_in held high through reset does not create a rising-edge capture.
- Capture latency:
  - An event_in transition that meets setup before clk edge N produces cap_pulse in cycle N+SYNC_STAGES.
  - The value written is count_in sampled at that same clk edge.
  - No correction for synchroniser delay is applied.
- FIFO:
  - push = cap_pulse; pop = cap_valid & cap_ready.
  - Register-array storage, wrap-around read and write pointers, separate occupancy counter.
  - cap_data = mem[rd_ptr] (combinational from registered storage). cap_data is don't-care while cap_valid = 0, but must not be X after reset.
  - No fall-through: a push into an empty FIFO makes cap_valid = 1 the cycle after the push.
- Boundary conditions:
  - Push while not full: written; fill_level +1.
  - Push while full with no pop: entry dropped, FIFO unchanged, overflow set next cycle.
  - Push and pop same cycle while full: both occur (read-before-write); fill_level stays DEPTH; no overflow.
  - Push and pop same cycle while 0 < fill < DEPTH: both occur; fill_level unchanged.
  - Pop while empty: ignored; cap_valid is 0, so this cannot occur under the handshake.
  - Pointers wrap modulo DEPTH; fill_level never exceeds DEPTH.
- Overflow:
  - Stays set until ovf_clr.
  - ovf_clr together with a new drop in the same cycle: set wins.
- Reset mid-operation: all FIFO contents are discarded immediately (asynchronous); the post-reset mask restarts.
- count_in wrap (255→0) needs no special handling; timestamps are raw modulo-2^CW values.

Test Plan:
- Reset with event_in held at 1, edge_sel=00, release reset → no capture within 10 cycles; fill_level=0, cap_valid=0.
- edge_sel=00, count_in ramping from 0 after reset, event_in rising at the edge where count_in=20 → one entry; cap_data=22 (SYNC_STAGES=2); cap_valid rises one cycle after the capture cycle; falling edge produces no entry.
- edge_sel=10, cap_ready=0, toggle event_in 5 times with ≥4 cycles between toggles → fill_level reaches 4; 5th edge dropped; overflow=1; contents are the first four timestamps in order.
- From full, hold cap_ready=1 and place a push in the same cycle as a pop → fill_level stays 4; overflow not set; the new timestamp appears after the three older ones; drain yields strictly increasing values.
- Set overflow, assert ovf_clr in the same cycle as another dropped capture → overflow stays 1; assert ovf_clr alone → overflow=0 next cycle.
- Fill with 2 entries, pulse reset mid-stream → fill_level=0, cap_valid=0 immediately; a rising edge within the first 3 cycles after release is ignored; a later edge is captured normally. edge_sel=11 during the same sequence → no captures.
